// File: rtl/tri_pixel_collector.sv
// Captures the rasterizer pixel stream into a 2**CW x 2**CW occupancy bitmap, counts distinct
// pixels, and unloads the bitmap row by row over valid/ready once the triangle ends.
module tri_pixel_collector #(
    parameter int unsigned CW = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  po,
    input  logic [CW-1:0]         xo,
    input  logic [CW-1:0]         yo,
    input  logic                  tri_busy,
    input  logic                  clr,
    input  logic                  row_ready,
    output logic                  row_valid,
    output logic [CW-1:0]         row_idx,
    output logic [(1<<CW)-1:0]    row_data,
    output logic [2*CW:0]         pix_cnt,
    output logic                  done,
    output logic                  coll_busy,
    output logic                  drop_err
);

    localparam int unsigned GW = 1 << CW;

    localparam logic [1:0] StCollect = 2'd0;
    localparam logic [1:0] StDump    = 2'd1;
    localparam logic [1:0] StFin     = 2'd2;

    localparam logic [2*CW:0] CntOne  = 1;
    localparam logic [CW-1:0] LastRow = CW'(GW - 1);

    logic [1:0]                 state_q, state_d;
    logic [GW-1:0][GW-1:0]      bitmap_q, bitmap_d;
    logic [2*CW:0]              cnt_q, cnt_d;
    logic                       busy_q;
    logic                       row_valid_q, row_valid_d;
    logic [CW-1:0]              row_idx_q, row_idx_d;
    logic [GW-1:0]              row_data_q, row_data_d;
    logic [2*CW:0]              pix_cnt_q, pix_cnt_d;
    logic                       done_q, done_d;
    logic                       coll_busy_q, coll_busy_d;
    logic                       drop_err_q, drop_err_d;
    logic                       eot;
    logic [CW-1:0]              next_row;

    assign eot      = busy_q & ~tri_busy;
    assign next_row = row_idx_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        bitmap_d    = bitmap_q;
        cnt_d       = cnt_q;
        row_valid_d = row_valid_q;
        row_idx_d   = row_idx_q;
        row_data_d  = row_data_q;
        pix_cnt_d   = pix_cnt_q;
        drop_err_d  = drop_err_q;
        done_d      = 1'b0;

        unique case (state_q)
            StCollect: begin
                if (clr) begin
                    bitmap_d = '0;
                    cnt_d    = '0;
                end else if (po) begin
                    bitmap_d[yo][xo] = 1'b1;
                    if (!bitmap_q[yo][xo]) begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                // Snapshot uses next-state values so a same-cycle pixel is included.
                if (eot) begin
                    state_d     = StDump;
                    pix_cnt_d   = cnt_d;
                    row_idx_d   = '0;
                    row_valid_d = 1'b1;
                    row_data_d  = bitmap_d[0];
                end
            end
            StDump: begin
                if (po) begin
                    drop_err_d = 1'b1;
                end
                if (row_valid_q && row_ready) begin
                    if (row_idx_q == LastRow) begin
                        state_d     = StFin;
                        row_valid_d = 1'b0;
                        row_idx_d   = '0;
                        row_data_d  = '0;
                        done_d      = 1'b1;
                    end else begin
                        row_idx_d  = next_row;
                        row_data_d = bitmap_q[next_row];
                    end
                end
            end
            StFin: begin
                if (po) begin
                    drop_err_d = 1'b1;
                end
                bitmap_d = '0;
                cnt_d    = '0;
                state_d  = StCollect;
            end
            default: begin
                state_d = StCollect;
            end
        endcase

        coll_busy_d = (state_d != StCollect);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StCollect;
            bitmap_q    <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            row_valid_q <= 1'b0;
            row_idx_q   <= '0;
            row_data_q  <= '0;
            pix_cnt_q   <= '0;
            done_q      <= 1'b0;
            coll_busy_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitmap_q    <= bitmap_d;
            cnt_q       <= cnt_d;
            busy_q      <= tri_busy;
            row_valid_q <= row_valid_d;
            row_idx_q   <= row_idx_d;
            row_data_q  <= row_data_d;
            pix_cnt_q   <= pix_cnt_d;
            done_q      <= done_d;
            coll_busy_q <= coll_busy_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign row_valid = row_valid_q;
    assign row_idx   = row_idx_q;
    assign row_data  = row_data_q;
    assign pix_cnt   = pix_cnt_q;
    assign done      = done_q;
    assign coll_busy = coll_busy_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_tri_pixel_collector.sv
// Bench for tri_pixel_collector: directed triangle table, backpressure, drop and reset
// sequences, then random triangles checked against a bitmap/popcount reference model.
module tb_tri_pixel_collector;

    logic       clk = 1'b0;
    logic       reset;
    logic       po;
    logic [2:0] xo, yo;
    logic       tri_busy, clr, row_ready;
    logic       row_valid;
    logic [2:0] row_idx;
    logic [7:0] row_data;
    logic [6:0] pix_cnt;
    logic       done, coll_busy, drop_err;

    tri_pixel_collector #(.CW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .po        (po),
        .xo        (xo),
        .yo        (yo),
        .tri_busy  (tri_busy),
        .clr       (clr),
        .row_ready (row_ready),
        .row_valid (row_valid),
        .row_idx   (row_idx),
        .row_data  (row_data),
        .pix_cnt   (pix_cnt),
        .done      (done),
        .coll_busy (coll_busy),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               n;
        logic [2:0]       px[8];
        logic [2:0]       py[8];
        logic [7:0][7:0]  rows;
        logic [6:0]       cnt;
    } vec_t;

    vec_t            vt[5];
    int              n_tests = 0;
    int              n_fail  = 0;
    logic            drop_exp = 1'b0;
    logic            drop_pend = 1'b0;
    logic [7:0][7:0] mdl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (drop_pend) drop_exp = 1'b1;
        drop_pend = 1'b0;
    endtask

    // Called with the eot cycle's inputs already driven; walks the whole dump.
    task automatic dump(input logic [7:0][7:0] er, input logic [6:0] ec, input int mode,
                        input int stall_row, input int stall_n, input int drop_row);
        int r = 0;
        int stalls = 0;
        bit fin = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            step();
            po  = 1'b0;
            clr = 1'b0;
            check("drop_err", drop_err, drop_exp);
            if (r < 8) begin
                check("row_valid", row_valid, 1);
                check("row_idx", row_idx, r);
                check("row_data", row_data, er[r]);
                check("coll_busy", coll_busy, 1);
                check("done_early", done, 0);
                if (r == 0) check("pix_cnt", pix_cnt, ec);
                if (mode == 1) begin
                    row_ready = 1'($urandom % 2);
                    tri_busy  = 1'($urandom % 2);
                    if ($urandom % 4 == 0) begin
                        po = 1'b1; xo = 3'($urandom); yo = 3'($urandom); drop_pend = 1'b1;
                    end
                end else if (r == stall_row && stalls < stall_n) begin
                    row_ready = 1'b0;
                    stalls++;
                end else begin
                    row_ready = 1'b1;
                end
                if (r == drop_row && stalls == 0) begin
                    po = 1'b1; xo = 3'd0; yo = 3'd0; drop_pend = 1'b1;
                end
                if (row_ready) r++;
            end else begin
                check("done", done, 1);
                check("row_valid_fin", row_valid, 0);
                check("coll_busy_fin", coll_busy, 1);
                row_ready = 1'b0;
                tri_busy  = 1'b0;
                step();
                check("done_pulse", done, 0);
                check("coll_busy_idle", coll_busy, 0);
                check("pix_cnt_hold", pix_cnt, ec);
                fin = 1;
            end
        end
        if (!fin) check("dump_timeout", 0, 1);
    endtask

    task automatic run_vec(input int k, input int stall_row, input int stall_n,
                           input int drop_row);
        tri_busy = 1'b1;
        step();
        for (int i = 0; i < vt[k].n; i++) begin
            po = 1'b1; xo = vt[k].px[i]; yo = vt[k].py[i];
            step();
        end
        po = 1'b0;
        tri_busy = 1'b0;
        dump(vt[k].rows, vt[k].cnt, 0, stall_row, stall_n, drop_row);
    endtask

    initial begin
        for (int k = 0; k < 5; k++) vt[k].rows = '0;
        vt[0].n = 3; vt[0].px[0:2] = '{1, 2, 1}; vt[0].py[0:2] = '{1, 1, 2};
        vt[0].rows[1] = 8'b00000110; vt[0].rows[2] = 8'b00000010; vt[0].cnt = 3;
        vt[1].n = 6; vt[1].px[0:5] = '{1, 2, 3, 1, 2, 1}; vt[1].py[0:5] = '{0, 0, 0, 1, 1, 2};
        vt[1].rows[0] = 8'b00001110; vt[1].rows[1] = 8'b00000110;
        vt[1].rows[2] = 8'b00000010; vt[1].cnt = 6;
        vt[2].n = 3; vt[2].px[0:2] = '{4, 4, 4}; vt[2].py[0:2] = '{5, 5, 5};
        vt[2].rows[5] = 8'b00010000; vt[2].cnt = 1;
        vt[3].n = 2; vt[3].px[0:1] = '{3, 5}; vt[3].py[0:1] = '{3, 6};
        vt[3].rows[3] = 8'b00001000; vt[3].rows[6] = 8'b00100000; vt[3].cnt = 2;
        vt[4].n = 1; vt[4].px[0] = 7; vt[4].py[0] = 7;
        vt[4].rows[7] = 8'b10000000; vt[4].cnt = 1;

        reset = 1'b1; po = 0; xo = 0; yo = 0; tri_busy = 0; clr = 0; row_ready = 0;
        #3;
        check("rst_row_valid", row_valid, 0);
        check("rst_row_idx", row_idx, 0);
        check("rst_row_data", row_data, 0);
        check("rst_pix_cnt", pix_cnt, 0);
        check("rst_done", done, 0);
        check("rst_coll_busy", coll_busy, 0);
        check("rst_drop_err", drop_err, 0);
        #10 reset = 1'b0;
        step();

        run_vec(0, -1, 0, -1);
        run_vec(1, -1, 0, -1);
        run_vec(2, -1, 0, -1);
        run_vec(0, 2, 3, -1);
        run_vec(2, -1, 0, 0);
        run_vec(3, -1, 0, -1);

        // Reset while row 4 is presented.
        tri_busy = 1'b1;
        step();
        po = 1'b1; xo = 3'd3; yo = 3'd4;
        step();
        po = 1'b0; tri_busy = 1'b0; row_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("mid_row_idx", row_idx, 4);
        check("mid_row_data", row_data, 8'b00001000);
        #2 reset = 1'b1;
        #1;
        check("mrst_row_valid", row_valid, 0);
        check("mrst_row_data", row_data, 0);
        check("mrst_coll_busy", coll_busy, 0);
        check("mrst_drop_err", drop_err, 0);
        check("mrst_pix_cnt", pix_cnt, 0);
        drop_exp = 1'b0;
        row_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mrst_no_done", done, 0);
        end
        #2 reset = 1'b0;
        step();
        run_vec(4, -1, 0, -1);

        // Random triangles vs. bitmap model.
        for (int t = 0; t < 25; t++) begin
            int n;
            mdl = '0;
            tri_busy = 1'b1; po = 0; clr = 0;
            step();
            n = $urandom_range(0, 30);
            for (int i = 0; i < n; i++) begin
                po  = ($urandom % 4 != 0);
                xo  = 3'($urandom); yo = 3'($urandom);
                clr = ($urandom % 16 == 0);
                if (clr) mdl = '0;
                else if (po) mdl[yo][xo] = 1'b1;
                step();
            end
            clr = 1'b0;
            po  = 1'($urandom % 2);
            xo  = 3'($urandom); yo = 3'($urandom);
            if (po) mdl[yo][xo] = 1'b1;
            tri_busy = 1'b0;
            dump(mdl, 7'($countones(mdl)), (t % 2 == 0) ? 1 : 0,
                 $urandom_range(0, 7), $urandom_range(0, 3), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tri_pixel_collector.md
Name: tri_pixel_collector

Overview:
- Sits directly downstream of the triangle rasterizer and captures its pixel stream (po/xo/yo) into an 8x8 occupancy bitmap.
- Counts distinct pixels for the current triangle.
- When the rasterizer drops busy, unloads the bitmap row by row over a valid/ready interface and reports the pixel count.
- Feeds the frame-compare / display stage.

Parameters:
- CW, 3, coordinate width; grid is 2**CW x 2**CW (8x8 at default).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- po  in  1  pixel strobe from rasterizer
- xo  in  CW  pixel x coordinate, valid when po=1
- yo  in  CW  pixel y coordinate, valid when po=1
- tri_busy  in  1  rasterizer busy; a 1->0 transition marks end of triangle
- clr  in  1  synchronous clear of bitmap and live count; honoured in COLLECT only
- row_ready  in  1  downstream accepts current row
- row_valid  out  1  row_idx/row_data valid
- row_idx  out  CW  row number (y) being presented
- row_data  out  2**CW  row bitmap; bit x = pixel (x, row_idx)
- pix_cnt  out  CW*2+1  distinct-pixel count of last completed triangle (7 bits at default, range 0..64)
- done  out  1  one-cycle pulse after last row accepted
- coll_busy  out  1  high in DUMP and FIN; host must not issue nt while high
- drop_err  out  1  sticky; pixel strobe arrived outside COLLECT

Behaviour:
- Reset (async, active-high), all outputs 0:
  - row_valid=0, row_idx=0, row_data=0, pix_cnt=0, done=0, coll_busy=0, drop_err=0.
  - Bitmap cleared, live count=0, busy_d=0, state=COLLECT.
  - Reset mid-DUMP abandons the transfer with no done pulse.
- busy_d: tri_busy registered every cycle. End-of-triangle event eot = busy_d & ~tri_busy.
- State COLLECT:
  - On po=1, set bitmap[yo][xo]. Live count increments only if that bit was 0; duplicates are not counted.
  - clr=1: bitmap and live count cleared. clr and po in the same cycle: clr wins and the pixel is discarded.
  - On eot: next state DUMP, pix_cnt <= live count (including any pixel written in the same cycle), row index <= 0.
  - po and eot in the same cycle: the pixel is written and counted before the snapshot.
- State DUMP:
  - row_valid=1, row_idx=current row, row_data=bitmap[row], all registered outputs.
  - First row appears the cycle after eot is sampled (latency 1).
  - Row advances only on row_valid & row_ready. row_idx/row_data are held stable while row_ready=0.
  - When row 2**CW-1 is accepted: row_valid<=0, next state FIN.
  - po=1 in DUMP or FIN: pixel ignored, drop_err<=1. drop_err clears only on reset.
  - eot in DUMP is ignored; clr is ignored.
- State FIN (one cycle):
  - done=1.
  - Bitmap and live count cleared.
  - pix_cnt holds until the next eot snapshot.
  - Next state COLLECT.
- coll_busy = (state != COLLECT), registered.
- Arithmetic: live count is CW*2+1 bits and cannot overflow, since max is 2**(2*CW).
- Coordinates are always in range by width; no wrap-around handling is needed.
- Empty triangle (eot with no pixels): full dump of 8 zero rows, pix_cnt=0, done pulses.

Test Plan:
- Pixels (1,1),(2,1),(1,2), then tri_busy 1->0, row_ready=1 -> rows 0..7 on consecutive cycles starting 1 cycle after eot; row1=8'b00000110, row2=8'b00000010, others 0; pix_cnt=3; done one cycle after row7.
- Rasterizer-style triangle (1,0),(3,0),(1,2) pixel stream, then eot -> rows 0..2 = 8'b00001110, 8'b00000110, 8'b00000010; pix_cnt=6.
- Pixel (4,5) sent 3 times, then eot -> row5=8'b00010000, pix_cnt=1.
- Backpressure: row_ready=0 for 3 cycles on row 2 -> row_idx=2 and row_data stable; no row skipped; done after 8 accepts.
- po=1 at (0,0) during DUMP -> drop_err=1 and stays; the next triangle's bitmap excludes (0,0).
- Reset asserted while row 4 is presented -> all outputs 0 immediately; no done. A subsequent triangle with pixel (7,7) dumps row7=8'b10000000, pix_cnt=1.
